// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, request/ack instruction memory read, one-cycle INSTR_VALID strobe.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter int WORD_SIZE      = 19,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FETCH_EN,
    input  logic                  JUMP,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
    output logic                  MEM_REQ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic                  MEM_ACK,
    input  logic [WORD_SIZE-1:0]  MEM_RDATA,
    output logic [WORD_SIZE-1:0]  INSTR,
    output logic                  INSTR_VALID,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  FETCH_BUSY,
    output logic                  FETCH_ERR
);

    // state | meaning
    // IDLE  | waiting for FETCH_EN; JUMP loads PC directly
    // REQ   | read request outstanding, waiting for MEM_ACK
    // DONE  | INSTR_VALID strobe cycle, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0]  r_instr;
    logic                  r_instr_valid;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_busy;
    logic                  r_flush;
    logic [ADDR_WIDTH-1:0] r_jump_addr;

    logic                  w_flush_now;
    logic [ADDR_WIDTH-1:0] w_flush_addr;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_fetch_err;
    logic             w_tmo;
`endif

    // A JUMP arriving in the same cycle as the ack (or timeout) counts as a flush.
    always_comb begin
        w_flush_now  = r_flush | JUMP;
        w_flush_addr = JUMP ? JUMP_ADDR : r_jump_addr;
        w_pc_inc     = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

`ifdef FETCH_TIMEOUT_EN
    always_comb begin
        w_tmo = (r_tmo_cnt == '0);
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc          <= '0;
            r_busy        <= 1'b0;
            r_flush       <= 1'b0;
            r_jump_addr   <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            r_instr_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (JUMP) begin
                        r_pc <= JUMP_ADDR;
                    end else if (FETCH_EN) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_busy     <= 1'b1;
                        r_state    <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        r_tmo_cnt  <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                REQ: begin
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        r_flush   <= 1'b0;
                        if (w_flush_now) begin
                            r_pc    <= w_flush_addr;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_instr       <= MEM_RDATA;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_inc;
                            r_state       <= DONE;
                        end
`ifdef FETCH_TIMEOUT_EN
                    end else if (w_tmo) begin
                        r_mem_req   <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_flush     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                        if (w_flush_now) begin
                            r_pc <= w_flush_addr;
                        end
`endif
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
`endif
                        if (JUMP) begin
                            r_flush     <= 1'b1;
                            r_jump_addr <= JUMP_ADDR;
                        end
                    end
                end
                DONE: begin
                    if (JUMP) begin
                        r_pc <= JUMP_ADDR;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign MEM_REQ     = r_mem_req;
    assign MEM_ADDR    = r_mem_addr;
    assign INSTR       = r_instr;
    assign INSTR_VALID = r_instr_valid;
    assign PC          = r_pc;
    assign FETCH_BUSY  = r_busy;
`ifdef FETCH_TIMEOUT_EN
    assign FETCH_ERR   = r_fetch_err;
`else
    assign FETCH_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; expected instructions are queued when the ack is driven
// and popped by a strobe monitor.
module tb_instruction_fetch_unit;

    localparam int WS = 19;
    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FETCH_EN;
    logic          JUMP;
    logic [AW-1:0] JUMP_ADDR;
    logic          MEM_REQ;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_ACK;
    logic [WS-1:0] MEM_RDATA;
    logic [WS-1:0] INSTR;
    logic          INSTR_VALID;
    logic [AW-1:0] PC;
    logic          FETCH_BUSY;
    logic          FETCH_ERR;

    instruction_fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FETCH_EN   (FETCH_EN),
        .JUMP       (JUMP),
        .JUMP_ADDR  (JUMP_ADDR),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_ACK    (MEM_ACK),
        .MEM_RDATA  (MEM_RDATA),
        .INSTR      (INSTR),
        .INSTR_VALID(INSTR_VALID),
        .PC         (PC),
        .FETCH_BUSY (FETCH_BUSY),
        .FETCH_ERR  (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            n_strobes = 0;
    logic [WS-1:0] exp_q[$];
    logic [WS-1:0] last_instr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples at the falling edge; stimulus acts 1ns later so the two never race.
    always @(negedge CLK) begin
        if (INSTR_VALID === 1'b1) begin
            n_strobes++;
            if (exp_q.size() == 0) chk("unexpected_strobe", INSTR_VALID, 1'b0);
            else                   chk("instr_data", INSTR, exp_q.pop_front());
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic fetch(input int waits, input logic [WS-1:0] data,
                         input logic [AW-1:0] addr, input logic [AW-1:0] pc_after);
        int s0;
        s0 = n_strobes;
        FETCH_EN = 1'b1;
        step();
        FETCH_EN = 1'b0;
        chk("req_start", MEM_REQ, 1'b1);
        chk("req_addr", MEM_ADDR, addr);
        chk("busy_req", FETCH_BUSY, 1'b1);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_hold", MEM_REQ, 1'b1);
            chk("addr_hold", MEM_ADDR, addr);
            chk("valid_while_wait", INSTR_VALID, 1'b0);
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = data;
        exp_q.push_back(data);
        step();
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        last_instr = data;
        chk("valid_strobe", INSTR_VALID, 1'b1);
        chk("instr_done", INSTR, data);
        chk("pc_after", PC, pc_after);
        chk("req_dropped", MEM_REQ, 1'b0);
        chk("busy_done", FETCH_BUSY, 1'b1);
        step();
        chk("valid_one_cycle", INSTR_VALID, 1'b0);
        chk("busy_idle", FETCH_BUSY, 1'b0);
        chk("instr_held", INSTR, data);
        chk("strobe_count", n_strobes, s0 + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        RST = 1'b1; FETCH_EN = 1'b0; JUMP = 1'b0; JUMP_ADDR = '0;
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        step();
        step();
        RST = 1'b0;
        step();
        chk("rst_pc", PC, 12'h000);
        chk("rst_req", MEM_REQ, 1'b0);
        chk("rst_addr", MEM_ADDR, 12'h000);
        chk("rst_instr", INSTR, 19'h0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_busy", FETCH_BUSY, 1'b0);
        chk("rst_err", FETCH_ERR, 1'b0);

        // zero-wait and 3-wait fetches
        fetch(0, 19'h4A123, 12'h000, 12'h001);
        fetch(3, 19'h15A5A, 12'h001, 12'h002);

        // JUMP beats FETCH_EN in IDLE, then wrap at top of address space
        JUMP = 1'b1; JUMP_ADDR = 12'hFFF; FETCH_EN = 1'b1;
        step();
        JUMP = 1'b0; FETCH_EN = 1'b0;
        chk("jump_idle_pc", PC, 12'hFFF);
        chk("jump_drops_fetch", MEM_REQ, 1'b0);
        chk("jump_idle_busy", FETCH_BUSY, 1'b0);
        fetch(0, 19'h7FFFF, 12'hFFF, 12'h000);

        // ack outside REQ is ignored
        s0 = n_strobes;
        MEM_ACK = 1'b1; MEM_RDATA = 19'h12345;
        step();
        step();
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        chk("idle_ack_busy", FETCH_BUSY, 1'b0);
        chk("idle_ack_pc", PC, 12'h000);
        chk("idle_ack_strobes", n_strobes, s0);

        // flush: two jumps during a waiting REQ, last one wins
        s0 = n_strobes;
        FETCH_EN = 1'b1;
        step();
        FETCH_EN = 1'b0;
        chk("flush_req", MEM_REQ, 1'b1);
        step();
        JUMP = 1'b1; JUMP_ADDR = 12'h123;
        step();
        JUMP_ADDR = 12'h200;
        step();
        JUMP = 1'b0; JUMP_ADDR = '0;
        chk("flush_req_hold", MEM_REQ, 1'b1);
        chk("flush_addr_hold", MEM_ADDR, 12'h000);
        chk("flush_pc_wait", PC, 12'h000);
        MEM_ACK = 1'b1; MEM_RDATA = 19'h0BEEF;
        step();
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        chk("flush_pc", PC, 12'h200);
        chk("flush_instr", INSTR, last_instr);
        chk("flush_req_drop", MEM_REQ, 1'b0);
        chk("flush_busy", FETCH_BUSY, 1'b0);
        chk("flush_no_valid", INSTR_VALID, 1'b0);
        step();
        chk("flush_strobes", n_strobes, s0);
        fetch(0, 19'h1B0C3, 12'h200, 12'h201);

        // JUMP coincident with ack flushes that fetch
        s0 = n_strobes;
        FETCH_EN = 1'b1;
        step();
        FETCH_EN = 1'b0;
        MEM_ACK = 1'b1; MEM_RDATA = 19'h2AAAA; JUMP = 1'b1; JUMP_ADDR = 12'h055;
        step();
        MEM_ACK = 1'b0; MEM_RDATA = '0; JUMP = 1'b0; JUMP_ADDR = '0;
        chk("jack_pc", PC, 12'h055);
        chk("jack_instr", INSTR, last_instr);
        chk("jack_busy", FETCH_BUSY, 1'b0);
        step();
        chk("jack_strobes", n_strobes, s0);

`ifdef FETCH_TIMEOUT_EN
        FETCH_EN = 1'b1;
        step();
        FETCH_EN = 1'b0;
        chk("tmo_req_1", MEM_REQ, 1'b1);
        for (int i = 2; i <= 16; i++) begin
            step();
            chk("tmo_req_hold", MEM_REQ, 1'b1);
        end
        step();
        chk("tmo_req_drop", MEM_REQ, 1'b0);
        chk("tmo_err", FETCH_ERR, 1'b1);
        chk("tmo_pc", PC, 12'h055);
        chk("tmo_busy", FETCH_BUSY, 1'b0);
        fetch(0, 19'h33333, 12'h055, 12'h056);
        chk("tmo_err_sticky", FETCH_ERR, 1'b1);
`else
        fetch(20, 19'h33333, 12'h055, 12'h056);
        chk("no_tmo_err", FETCH_ERR, 1'b0);
`endif

        // asynchronous reset mid-fetch
        s0 = n_strobes;
        FETCH_EN = 1'b1;
        step();
        FETCH_EN = 1'b0;
        chk("arst_req_before", MEM_REQ, 1'b1);
        #1 RST = 1'b1;
        #1;
        chk("arst_req", MEM_REQ, 1'b0);
        chk("arst_pc", PC, 12'h000);
        chk("arst_addr", MEM_ADDR, 12'h000);
        chk("arst_instr", INSTR, 19'h0);
        chk("arst_busy", FETCH_BUSY, 1'b0);
        chk("arst_err", FETCH_ERR, 1'b0);
        step();
        RST = 1'b0;
        MEM_ACK = 1'b1; MEM_RDATA = 19'h55555;
        step();
        step();
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        chk("late_ack_strobes", n_strobes, s0);
        chk("late_ack_busy", FETCH_BUSY, 1'b0);
        chk("late_ack_instr", INSTR, 19'h0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream stage of the instruction register in the 19-bit CPU. Holds the program counter (PC), runs a request/acknowledge read to instruction memory when the control unit asks for the next instruction, and presents the fetched word on `INSTR` with a one-cycle `INSTR_VALID` strobe. The instruction register loads on that strobe. Also accepts PC loads (jumps) from the control unit, including a flush of an in-flight fetch.

## Interface
- `WORD_SIZE`, 19: instruction word width.
- `ADDR_WIDTH`, 12: PC and memory address width; matches the IR address operand field.
- `TIMEOUT_CYCLES`, 16: ack watchdog limit, only used when `FETCH_TIMEOUT_EN` is defined.

Ports:
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `FETCH_EN` in 1: request to fetch the next instruction; sampled only in IDLE.
- `JUMP` in 1: load the PC from `JUMP_ADDR`.
- `JUMP_ADDR` in ADDR_WIDTH: jump target.
- `MEM_REQ` out 1: memory read request.
- `MEM_ADDR` out ADDR_WIDTH: read address.
- `MEM_ACK` in 1: memory has `MEM_RDATA` valid this cycle.
- `MEM_RDATA` in WORD_SIZE: read data.
- `INSTR` out WORD_SIZE: last delivered instruction; held between fetches.
- `INSTR_VALID` out 1: one-cycle strobe; IR load enable.
- `PC` out ADDR_WIDTH: current program counter.
- `FETCH_BUSY` out 1: high whenever the state is not IDLE.
- `FETCH_ERR` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, DONE. All outputs are registered.
- **IDLE**
  - `JUMP`=1: PC <= `JUMP_ADDR`; stay in IDLE. `JUMP` has priority over `FETCH_EN`; a `FETCH_EN` in the same cycle is dropped.
  - Else `FETCH_EN`=1: `MEM_REQ` <= 1, `MEM_ADDR` <= PC; go to REQ.
- **REQ**
  - `MEM_REQ` and `MEM_ADDR` are held stable until `MEM_ACK` is sampled high.
  - On `MEM_ACK` with no flush pending: `INSTR` <= `MEM_RDATA`, `MEM_REQ` <= 0, PC <= PC+1 (modulo 2^ADDR_WIDTH, so 0xFFF wraps to 0x000); go to DONE.
  - `JUMP`=1 in REQ: latch `JUMP_ADDR` and set the flush flag. A later `JUMP` before the ack overwrites the latched address.
  - On `MEM_ACK` with flush set: `INSTR` is unchanged, `MEM_REQ` <= 0, PC <= latched jump address, flush is cleared; go to IDLE with no `INSTR_VALID`.
  - `JUMP` in the same cycle as `MEM_ACK` counts as a flush of that fetch.
- **DONE**
  - `INSTR_VALID`=1 for exactly this one cycle.
  - `JUMP`=1: PC <= `JUMP_ADDR`.
  - Always return to IDLE. `FETCH_EN` is not accepted in DONE.
- `FETCH_BUSY` = (state != IDLE).

## Timing
- Reset values: PC=0, `MEM_REQ`=0, `MEM_ADDR`=0, `INSTR`=0, `INSTR_VALID`=0, `FETCH_ERR`=0, flush=0, state IDLE.
- Reset asserted mid-fetch drops `MEM_REQ` immediately (asynchronous); any late `MEM_ACK` after reset is ignored in IDLE.
- `FETCH_EN` sampled at edge 0 gives `MEM_REQ` high after edge 0.
- Zero-wait memory (`MEM_ACK` high in the first REQ cycle): ack sampled at edge 1, `INSTR`/`INSTR_VALID` visible after edge 1. Minimum latency is 2 edges from request to strobe.
- A new fetch can begin at the earliest one cycle after DONE: 3 cycles per instruction at zero wait.
- `MEM_ACK` outside REQ is ignored.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter runs while in REQ and clears on entering REQ.
  - If `TIMEOUT_CYCLES` cycles pass without `MEM_ACK`: `MEM_REQ` <= 0, `FETCH_ERR` <= 1, flush cleared, PC unchanged (or set to the latched jump address if a flush was pending); go to IDLE.
  - `FETCH_ERR` stays high until `RST`.
- `FETCH_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `FETCH_ERR` is tied to 0; no counter logic.

## Test plan
- Reset, then `FETCH_EN` pulse; memory acks in the first REQ cycle with 0x4A123 -> `MEM_ADDR`=0x000, `INSTR`=0x4A123, `INSTR_VALID` high one cycle 2 edges after `FETCH_EN`, PC=0x001.
- Memory acks after 3 wait cycles -> `MEM_REQ`/`MEM_ADDR` stable all 4 REQ cycles; a single `INSTR_VALID`; `FETCH_BUSY` high from request through DONE.
- `JUMP` to 0x0FFF in IDLE, then fetch -> `MEM_ADDR`=0xFFF; after the ack PC wraps to 0x000.
- `JUMP` to 0x200 during a waiting REQ, then ack -> no `INSTR_VALID`, `INSTR` unchanged, PC=0x200; the next fetch reads 0x200.
- `RST` asserted while `MEM_REQ`=1 -> `MEM_REQ` drops without waiting for an edge; all outputs at reset values; a late `MEM_ACK` produces no strobe.
- With `FETCH_TIMEOUT_EN`, never ack -> `MEM_REQ` drops after 16 REQ cycles, `FETCH_ERR`=1 sticky, PC unchanged; a subsequent acked fetch still works.
